// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared defaults and state encoding for the MM input skew block
// Purpose: default systolic-array edge size and lane width, skew FSM state
//          encoding, and a counter-width helper used by mm_in_skew.
// Ports:   none (package).
package mm_pkg;

  localparam int MM_A_SIZE     = 24;
  localparam int MM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } skew_state_t;

  // clog2 that never returns 0, so a single-lane build still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_skew_lane.sv
// rtl/mm_skew_lane.sv - enabled, zero-reset delay line for one skewed lane
// Purpose: delays din by exactly depth enabled steps; contents only move when en=1.
// Ports:   clk, rst (sync active-high), en (shift strobe),
//          din (lane input), dout (value shifted in depth steps ago, 0 if none).
module mm_skew_lane
  import mm_pkg::*;
#(
  parameter int depth      = 1,
  parameter int data_width = MM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] dout
);

  logic [data_width-1:0] taps [depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < depth; j++) taps[j] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int j = 1; j < depth; j++) taps[j] <= taps[j-1];
    end
  end

  assign dout = taps[depth-1];

endmodule

// File: rtl/mm_in_skew.sv
// rtl/mm_in_skew.sv - diagonal input skew feeding one edge of the systolic array
// Purpose: lane i of the output is lane i of the input delayed i steps. After the
//          in_last beat, A_size-1 zero-input drain steps flush the delay lines.
//          Optional macro MM_SKEW_PERF_CNT_EN adds a saturating stall counter.
// Ports:   clk, rst (sync active-high)
//          in_valid/in_ready/in_last/in_data   upstream beat stream
//          out_valid/out_ready/out_last/out_data skewed beat stream (registered)
//          busy       high while not IDLE
//          stall_cnt  (MM_SKEW_PERF_CNT_EN only) cycles with out_valid & ~out_ready
module mm_in_skew
  import mm_pkg::*;
#(
  parameter int A_size     = MM_A_SIZE,
  parameter int data_width = MM_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic [A_size*data_width-1:0] in_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [A_size*data_width-1:0] out_data,
  output logic                         busy
`ifdef MM_SKEW_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int            CW         = cnt_width(A_size);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((A_size > 1) ? A_size - 2 : 0);

  skew_state_t state;
  logic [CW-1:0] drain_cnt;

  logic adv;
  logic accept;
  logic drain_step;
  logic step;
  logic last_step;
  logic [A_size*data_width-1:0] skewed;

  // The output register can take a new beat when empty or being drained downstream.
  assign adv        = ~out_valid | out_ready;
  assign in_ready   = adv & (state != ST_DRAIN);
  assign accept     = in_valid & in_ready;
  assign drain_step = (state == ST_DRAIN) & adv;
  assign step       = accept | drain_step;
  assign busy       = (state != ST_IDLE);

  // Single-lane arrays have no drain, so the in_last beat itself is the final one.
  assign last_step  = (A_size == 1) ? (accept & in_last)
                                    : (drain_step & (drain_cnt == DRAIN_LAST));

  // During drain no beat is accepted, so every lane shifts in zero.
  assign skewed[data_width-1:0] = accept ? in_data[data_width-1:0] : '0;

  for (genvar i = 1; i < A_size; i++) begin : g_lane
    mm_skew_lane #(
      .depth      (i),
      .data_width (data_width)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (step),
      .din  (accept ? in_data[i*data_width +: data_width] : '0),
      .dout (skewed[i*data_width +: data_width])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      // Output register holds everything while stalled (adv=0).
      if (step) begin
        out_valid <= 1'b1;
        out_data  <= skewed;
        out_last  <= last_step;
      end else if (adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (in_last) begin
              state     <= (A_size == 1) ? ST_IDLE : ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_step) begin
            if (drain_cnt == DRAIN_LAST) begin
              state     <= ST_IDLE;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MM_SKEW_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid & ~out_ready & (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mm_in_skew.md
MM_IN_SKEW -- requirements
Module: mm_in_skew

Interface
REQ-001 Parameter A_size, default 24, SHALL set the lane count (systolic array edge).
REQ-002 Parameter data_width, default 8, SHALL set the bits per lane.
REQ-003 clk  input  1  sole clock; all logic SHALL be on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream beat valid (fed by the MM input buffer F or W stream).
REQ-006 in_last  input  1  marks final beat of a block pass.
REQ-007 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-008 in_data  input  A_size*data_width  lane i = bits [i*data_width +: data_width].
REQ-009 out_valid  output  1  skewed beat valid.
REQ-010 out_last  output  1  final skewed beat of the pass.
REQ-011 out_ready  input  1  array accepts beat.
REQ-012 out_data  output  A_size*data_width  skewed lanes.
REQ-013 busy  output  1  high when state is not IDLE.

Function
REQ-014 States SHALL be IDLE, STREAM, DRAIN.
REQ-015 adv = ~out_valid | out_ready; in_ready SHALL equal adv & (state != DRAIN).
REQ-016 A step SHALL occur on (in_valid & in_ready) or (state==DRAIN & adv); no other event moves lane delay lines.
REQ-017 On step k, output lane i SHALL be input lane i of step k-i (lane 0 undelayed, lane A_size-1 delayed A_size-1 steps); missing history SHALL read 0.
REQ-018 out_data/out_valid SHALL be registered: step in cycle t -> out_valid=1 in t+1; adv without step -> out_valid=0 next cycle.
REQ-019 While out_valid & ~out_ready, out_data, out_valid, out_last SHALL hold unchanged.
REQ-020 IDLE -> STREAM on first accepted beat; STREAM -> DRAIN when accepted beat has in_last, unless A_size==1 (then -> IDLE).
REQ-021 DRAIN SHALL perform exactly A_size-1 steps with lane-0 input forced to 0, then -> IDLE.
REQ-022 Output beats per pass SHALL be N + A_size-1 for N accepted beats.
REQ-023 out_last SHALL be 1 only on the final drain beat (on the in_last beat when A_size==1).
REQ-024 in_valid gaps in STREAM SHALL insert no bubbles into the skew (delay lines frozen).
REQ-025 Drain counter width SHALL be clog2(A_size); it SHALL reset to 0 on DRAIN entry.
REQ-026 A new pass SHALL be accepted in the cycle after DRAIN -> IDLE; delay lines SHALL hold zeros at pass start.

Reset
REQ-027 rst SHALL force state=IDLE, out_valid=0, out_last=0, out_data=0, all delay lines=0, drain counter=0, in_ready=1 next cycle.
REQ-028 rst mid-pass SHALL discard the pass; no out_last is emitted for it.

Configuration
REQ-029 Macro MM_SKEW_PERF_CNT_EN defined: add output stall_cnt (32 bits) counting cycles with out_valid & ~out_ready, cleared by rst, saturating at all-ones.
REQ-030 Macro undefined: no stall_cnt port, no counter logic.

Structure
REQ-031 Shared package mm_pkg SHALL hold A_size/data_width defaults and the state encoding constants.
REQ-032 Sub-module mm_skew_lane (parameterised depth, enable, zero-reset shift register) SHALL implement one lane's delay; instantiated per lane 1..A_size-1.

Verification
REQ-033 A_size=4, 3 beats lanes {1,2,3,4},{5,6,7,8},{9,10,11,12}, out_ready=1 -> 6 beats: {1,0,0,0},{5,2,0,0},{9,6,3,0},{0,10,7,4},{0,0,11,8},{0,0,0,12}; out_last on 6th.
REQ-034 Same stimulus, out_ready toggled 1/0 each cycle -> identical 6 beats, held stable while stalled.
REQ-035 in_valid with 2-cycle gaps between beats -> same 6 beats, no bubble beats in skew content.
REQ-036 rst asserted during DRAIN step 1 -> out_valid=0, busy=0 next cycle; following pass output starts from zeroed history.
REQ-037 A_size=1, 2 beats {7},{9} -> outputs {7},{9}, out_last on {9}, no drain.
REQ-038 MM_SKEW_PERF_CNT_EN defined, out_ready held 0 for 5 cycles with out_valid=1 -> stall_cnt=5.
